// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared constants for the iterative multiply/divide unit
// Op encodings, condition-code bit positions (ALU flag ordering) and sequencer states.
package alu_muldiv_seq_pkg;

  localparam logic [1:0] MD_MULL = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;
  localparam logic [1:0] MD_MODU = 2'b11;

  localparam int CC_SIGN   = 0;
  localparam int CC_CARRY  = 1;
  localparam int CC_ZERO   = 2;
  localparam int CC_PARITY = 3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq_md_flags.sv
// rtl/alu_muldiv_seq_md_flags.sv - condition codes for a finished multiply/divide result
// Purely combinational; the top registers the output on the edge entering DONE.
module alu_muldiv_seq_md_flags
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] result,
  input  logic [1:0]       op,
  input  logic             divzero,
  input  logic             hi_nonzero,
  output logic [3:0]       cc
);

  always_comb begin
    cc            = '0;
    cc[CC_SIGN]   = result[WIDTH-1];
    cc[CC_ZERO]   = (result == '0);
    cc[CC_PARITY] = ^result;
    // CARRY flags lost product bits on MULL and a zero divisor on divides
    case (op)
      MD_MULL: cc[CC_CARRY] = hi_nonzero;
      MD_MULH: cc[CC_CARRY] = 1'b0;
      default: cc[CC_CARRY] = divzero;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative shift-add multiply / restoring divide, one bit per clock
// Sixteen RUN steps per operation; RESULT and CC load on the edge entering DONE.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       MD_OPX,
  input  logic [WIDTH-1:0] ARGA,
  input  logic [WIDTH-1:0] ARGB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [3:0]       CC
);

  md_state_e        state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cc_q, cc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fin_result;
  logic [3:0]       fin_cc;
  logic             accept;

  // hi/lo hold {hi,lo} for multiply and {rem,quo} for divide; opnd is A or B accordingly
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    rem_s    = {hi_q, lo_q[WIDTH-1]};
    trial_ok = (rem_s >= {1'b0, opnd_q});
    // when the trial succeeds the difference is below the divisor, so WIDTH bits suffice
    trial    = rem_s[WIDTH-1:0] - opnd_q;
    div_hi   = trial_ok ? trial : rem_s[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], trial_ok};

    step_hi = op_q[1] ? div_hi : mul_hi;
    step_lo = op_q[1] ? div_lo : mul_lo;

    case (op_q)
      MD_MULL: fin_result = step_lo;
      MD_MULH: fin_result = step_hi;
      MD_DIVU: fin_result = step_lo;
      default: fin_result = step_hi;
    endcase
  end

  alu_muldiv_seq_md_flags #(.WIDTH(WIDTH)) u_md_flags (
    .result     (fin_result),
    .op         (op_q),
    .divzero    (divz_q),
    .hi_nonzero (|step_hi),
    .cc         (fin_cc)
  );

  assign accept = START && (state_q == MD_IDLE || state_q == MD_DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    cc_d     = cc_q;

    case (state_q)
      MD_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d  = MD_DONE;
          result_d = fin_result;
          cc_d     = fin_cc;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    // an accept in DONE overrides the return to IDLE, giving back-to-back operation
    if (accept) begin
      state_d = MD_RUN;
      cnt_d   = '0;
      op_d    = MD_OPX;
      divz_d  = (ARGB == '0);
      hi_d    = '0;
      if (MD_OPX[1]) begin
        opnd_d = ARGB;
        lo_d   = ARGA;
      end else begin
        opnd_d = ARGA;
        lo_d   = ARGB;
      end
    end

    busy_d = (state_d == MD_RUN);
    done_d = (state_d == MD_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MULL;
      opnd_q   <= '0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      cc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      cc_q     <= cc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign CC     = cc_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - scoreboard bench for the iterative multiply/divide unit
module tb_alu_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  MD_OPX;
  logic [15:0] ARGA;
  logic [15:0] ARGB;
  logic        BUSY;
  logic        DONE;
  logic [15:0] RESULT;
  logic [3:0]  CC;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  cc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  alu_muldiv_seq #(.WIDTH(16), .CNTW(4)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .MD_OPX (MD_OPX),
    .ARGA   (ARGA),
    .ARGB   (ARGB),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT),
    .CC     (CC)
  );

  always #5 CLK = ~CLK;

  // reference: cc = {PARITY, ZERO, CARRY, SIGN}
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] r;
    logic        c;
    p = {16'd0, a} * {16'd0, b};
    case (op)
      2'b00: begin r = p[15:0];  c = (p[31:16] != 16'd0); end
      2'b01: begin r = p[31:16]; c = 1'b0; end
      2'b10: begin r = (b == 16'd0) ? 16'hFFFF : a / b; c = (b == 16'd0); end
      default: begin r = (b == 16'd0) ? a : a % b; c = (b == 16'd0); end
    endcase
    model.res = r;
    model.cc  = {^r, (r == 16'd0), c, r[15]};
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input exp_t e);
    @(negedge CLK);
    START  = 1'b1;
    MD_OPX = op;
    ARGA   = a;
    ARGB   = b;
    sb.push_back(e);
    @(negedge CLK);
    START  = 1'b0;
    MD_OPX = 2'($urandom);
    ARGA   = 16'($urandom);
    ARGB   = 16'($urandom);
  endtask

  task automatic wait_done(output int edges, output int busy_cycles, output bit seen);
    edges       = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (edges < 40) begin
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (BUSY) busy_cycles++;
      @(negedge CLK);
      edges++;
    end
  endtask

  task automatic test_single_op(input string name, input logic [1:0] op, input logic [15:0] a,
                                input logic [15:0] b, input exp_t e);
    int   edges;
    int   busy_cycles;
    bit   seen;
    exp_t got;
    start_op(op, a, b, e);
    wait_done(edges, busy_cycles, seen);
    n_total++;
    if (!seen) begin
      $display("FAIL %s timeout: no DONE within %0d cycles", name, edges);
      if (sb.size() > 0) got = sb.pop_front();
      return;
    end
    n_pass++;
    got = sb.pop_front();
    n_total++;
    if (edges !== 16) $display("FAIL %s latency: got %0d edges after accept+1, want 16", name, edges);
    else n_pass++;
    n_total++;
    if (busy_cycles !== 16) $display("FAIL %s busy: got %0d cycles, want 16", name, busy_cycles);
    else n_pass++;
    n_total++;
    if (RESULT !== got.res) $display("FAIL %s result: got %h want %h", name, RESULT, got.res);
    else n_pass++;
    n_total++;
    if (CC !== got.cc) $display("FAIL %s cc: got %b want %b", name, CC, got.cc);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if ({DONE, BUSY} !== 2'b00) $display("FAIL %s pulse: got DONE=%b BUSY=%b want 0 0", name, DONE, BUSY);
    else n_pass++;
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    START  = 1'b0;
    MD_OPX = 2'b00;
    ARGA   = 16'd0;
    ARGB   = 16'd0;
    repeat (3) @(negedge CLK);
    n_total++;
    if ({BUSY, DONE, RESULT, CC} !== 22'd0)
      $display("FAIL reset_state: got BUSY=%b DONE=%b RESULT=%h CC=%b want all 0", BUSY, DONE, RESULT, CC);
    else n_pass++;
    RESET = 1'b0;
  endtask

  task automatic test_mul();
    test_single_op("mull_1234x10", 2'b00, 16'h1234, 16'h0010, '{16'h2340, 4'b0010});
    test_single_op("mulh_1234x10", 2'b01, 16'h1234, 16'h0010, '{16'h0001, 4'b1000});
  endtask

  task automatic test_div();
    test_single_op("divu_100_7", 2'b10, 16'd100, 16'd7, '{16'h000E, 4'b1000});
    test_single_op("modu_100_7", 2'b11, 16'd100, 16'd7, '{16'h0002, 4'b1000});
  endtask

  task automatic test_divzero();
    test_single_op("divu_ff_0", 2'b10, 16'h00FF, 16'h0000, '{16'hFFFF, 4'b0011});
    test_single_op("modu_ff_0", 2'b11, 16'h00FF, 16'h0000, '{16'h00FF, 4'b0010});
  endtask

  task automatic test_back_to_back();
    int   edges;
    int   busy_cycles;
    bit   seen;
    exp_t got;
    start_op(2'b00, 16'h1234, 16'h0010, '{16'h2340, 4'b0010});
    wait_done(edges, busy_cycles, seen);
    n_total++;
    if (!seen) begin
      $display("FAIL b2b_first timeout: no DONE within %0d cycles", edges);
      if (sb.size() > 0) got = sb.pop_front();
      return;
    end
    n_pass++;
    got = sb.pop_front();
    n_total++;
    if (RESULT !== got.res) $display("FAIL b2b_first result: got %h want %h", RESULT, got.res);
    else n_pass++;
    START  = 1'b1;
    MD_OPX = 2'b00;
    ARGA   = 16'hFFFF;
    ARGB   = 16'hFFFF;
    sb.push_back('{16'h0001, 4'b1010});
    @(negedge CLK);
    START = 1'b0;
    ARGA  = 16'h0003;
    ARGB  = 16'h0005;
    n_total++;
    if ({BUSY, DONE, RESULT} !== {2'b10, 16'h2340})
      $display("FAIL b2b_gap: got BUSY=%b DONE=%b RESULT=%h want 1 0 2340", BUSY, DONE, RESULT);
    else n_pass++;
    wait_done(edges, busy_cycles, seen);
    n_total++;
    if (!seen) begin
      $display("FAIL b2b_second timeout: no DONE within %0d cycles", edges);
      if (sb.size() > 0) got = sb.pop_front();
      return;
    end
    n_pass++;
    got = sb.pop_front();
    n_total++;
    if (edges !== 16) $display("FAIL b2b_second latency: got %0d want 16", edges);
    else n_pass++;
    n_total++;
    if ({RESULT, CC} !== {got.res, got.cc})
      $display("FAIL b2b_second result: got %h/%b want %h/%b", RESULT, CC, got.res, got.cc);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_ignore_start();
    int   edges;
    int   busy_cycles;
    bit   seen;
    exp_t got;
    start_op(2'b10, 16'd1000, 16'd3, model(2'b10, 16'd1000, 16'd3));
    repeat (5) @(negedge CLK);
    START  = 1'b1;
    MD_OPX = 2'b00;
    ARGA   = 16'd7;
    ARGB   = 16'd9;
    @(negedge CLK);
    START = 1'b0;
    wait_done(edges, busy_cycles, seen);
    n_total++;
    if (!seen) begin
      $display("FAIL ignore_start timeout: no DONE within %0d cycles", edges);
      if (sb.size() > 0) got = sb.pop_front();
      return;
    end
    n_pass++;
    got = sb.pop_front();
    n_total++;
    if (edges + 6 !== 16) $display("FAIL ignore_start latency: got %0d want 16", edges + 6);
    else n_pass++;
    n_total++;
    if ({RESULT, CC} !== {got.res, got.cc})
      $display("FAIL ignore_start result: got %h/%b want %h/%b", RESULT, CC, got.res, got.cc);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    @(negedge CLK);
    START  = 1'b1;
    MD_OPX = 2'b10;
    ARGA   = 16'h1234;
    ARGB   = 16'h0005;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    n_total++;
    if ({BUSY, DONE, RESULT, CC} !== 22'd0)
      $display("FAIL reset_midrun: got BUSY=%b DONE=%b RESULT=%h CC=%b want all 0", BUSY, DONE, RESULT, CC);
    else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (DONE || BUSY) saw_done = 1'b1;
      @(negedge CLK);
    end
    n_total++;
    if (saw_done) $display("FAIL reset_midrun_quiet: got activity after reset want none");
    else n_pass++;
    test_single_op("after_reset_divu", 2'b10, 16'h1234, 16'h0005, model(2'b10, 16'h1234, 16'h0005));
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom);
      a  = 16'($urandom);
      b  = (i % 5 == 4) ? 16'd0 : 16'($urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : $urandom);
      test_single_op("random", op, a, b, model(op, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_back_to_back();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative multiply/divide unit beside the existing single-cycle ALU.
- Consumes the same post-mux operands, ALUA_DATA and ALUB_DATA, and produces a 16-bit result plus a 4-bit condition code in the ALU's flag ordering.
- The sequencer loads the condition-code latch from CC when DONE pulses.
- Multiply uses shift-add and divide uses restoring division, one bit per clock.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported in silicon.
- CNTW, 4, iteration counter width; must equal log2(WIDTH).

Ports:
- CLK  in  1  system clock; all state on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE or DONE
- MD_OPX  in  2  00 MULL (low product), 01 MULH (high product, unsigned), 10 DIVU (quotient), 11 MODU (remainder)
- ARGA  in  16  multiplicand / dividend (from ALUA_DATA)
- ARGB  in  16  multiplier / divisor (from ALUB_DATA)
- BUSY  out  1  high while iterating
- DONE  out  1  one-cycle pulse; RESULT/CC valid
- RESULT  out  16  result, held until next accepted START
- CC  out  4  [0] SIGN, [1] CARRY, [2] ZERO, [3] PARITY

Behaviour:
- States: IDLE, RUN, DONE. Every clock edge with RESET high forces IDLE, cnt=0, RESULT=0, CC=0, BUSY=0, DONE=0. Reset mid-RUN abandons the operation and produces no DONE.
- Acceptance: START=1 at edge k while in IDLE or DONE latches ARGA, ARGB and MD_OPX, clears cnt, and enters RUN.
  - START in RUN is ignored; there is no queue.
  - Operands and MD_OPX are not resampled after acceptance.
- Outputs are registered: BUSY=1 exactly while state==RUN, DONE=1 exactly while state==DONE.
- RUN: one step per edge, cnt increments.
  - After the edge where cnt==15 (16 steps, edge k+16), state becomes DONE and RESULT/CC update on that same edge.
  - DONE is therefore visible in the cycle after edge k+16, i.e. 17 cycles after the accept edge.
- DONE: lasts one cycle.
  - With START=0 the unit returns to IDLE.
  - With START=1 it accepts a new operation back-to-back and enters RUN; DONE deasserts.
- Multiply, 33-bit accumulator {c, hi[15:0], lo[15:0]}:
  - Init: hi=0, lo=ARGB.
  - Each step: if lo[0], {c,hi} = hi + A; then shift {c,hi,lo} right by 1.
  - After 16 steps {hi,lo} = A*B, unsigned.
  - MULL returns lo; MULH returns hi.
- Divide, restoring:
  - Init: rem=0 (17 bits), quo=ARGA.
  - Each step: shift {rem,quo} left 1, trial = rem - {0,B}. If the trial is non-negative, rem=trial and quo[0]=1; otherwise quo[0]=0.
  - DIVU returns quo; MODU returns rem[15:0].
- Divide by zero: no special path. The algorithm naturally yields quo=0xFFFF and rem=ARGA, and CARRY is set.
- Flags are computed from the final RESULT:
  - SIGN = RESULT[15].
  - ZERO = (RESULT==0).
  - PARITY = XOR-reduce(RESULT), i.e. 1 when the number of ones is odd.
  - CARRY: MULL → hi!=0 (overflow); MULH → 0; DIVU/MODU → (B==0).
- RESULT and CC change only on the edge entering DONE or on reset. They keep their value through IDLE and through the following RUN.

Decomposition:
- Add to the shared constants include:
  - MD_OPX encodings MD_MULL, MD_MULH, MD_DIVU, MD_MODU.
  - CC bit indices CC_SIGN=0, CC_CARRY=1, CC_ZERO=2, CC_PARITY=3.
  - State encodings MD_IDLE, MD_RUN, MD_DONE.
- The ALU flag wiring uses the same CC bit constants.
- One sub-module is natural: md_flags, combinational RESULT/op/divzero → CC. The datapath and FSM stay in alu_muldiv_seq.

Test Plan:
- MULL 0x1234 × 0x0010 → DONE exactly 17 cycles after the accept edge; RESULT=0x2340; CC: CARRY=1, SIGN=0, ZERO=0, PARITY=0 (4 ones). Repeat as MULH → RESULT=0x0001, CARRY=0, PARITY=1.
- DIVU 100/7 → RESULT=0x000E; MODU 100/7 → RESULT=0x0002. BUSY high for exactly 16 cycles in each case; DONE is a single-cycle pulse.
- DIVU 0x00FF/0 → RESULT=0xFFFF, CARRY=1, SIGN=1, ZERO=0, PARITY=0. MODU 0x00FF/0 → RESULT=0x00FF, CARRY=1.
- START=1 while in DONE with MULL 0xFFFF×0xFFFF → no IDLE gap; new RUN starts; RESULT=0x0001, CARRY=1. Previous RESULT is held until this DONE.
- START pulsed mid-RUN with different operands → ignored; the original result is produced at the original time.
- RESET asserted at cnt=8 of a DIVU → next cycle shows IDLE, BUSY=0, RESULT=0, CC=0; no DONE ever appears. A subsequent START runs normally.
